// File: rtl/nes_multi_reader.sv
// nes_multi_reader: self-timed NES controller poller for 1..4 pads.
// Every POLL_CYCLES clocks it strobes nes_latch, clocks seven nes_pulse
// periods and samples each data pad through a SYNC_STAGES synchroniser.
// At the end of each frame it publishes the held button state and the
// newly pressed buttons, together with a one-cycle valid pulse.
//
// Ports:
//   clk        system clock
//   hard_reset asynchronous active-high reset
//   poll_en    1 = free-running polling enabled
//   nes_data   raw serial data per pad, active-low
//   nes_latch  registered latch strobe to the pads
//   nes_pulse  registered shift clock to the pads
//   buttons    held state, 8 bits per controller, bit 0 = A
//   pressed    buttons that went 0->1 this frame (one-cycle pulse)
//   valid      one-cycle pulse when buttons/pressed update
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for the poll tick, pads idle
// S_LATCH | latch high for 2*HALF_PERIOD, bit 0 sampled on last cycle
// S_P_HIGH| pulse high for HALF_PERIOD
// S_P_LOW | pulse low for HALF_PERIOD, bit k sampled on last cycle
// S_DONE  | one cycle, results published
module nes_multi_reader #(
  parameter int NUM_CTRL    = 1,
  parameter int HALF_PERIOD = 300,
  parameter int POLL_CYCLES = 833333,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  hard_reset,
  input  logic                  poll_en,
  input  logic [NUM_CTRL-1:0]   nes_data,
  output logic                  nes_latch,
  output logic                  nes_pulse,
  output logic [8*NUM_CTRL-1:0] buttons,
  output logic [8*NUM_CTRL-1:0] pressed,
  output logic                  valid
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(2 * HALF_PERIOD);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_P_HIGH,
    S_P_LOW,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            bit_q, bit_d;
  logic [PW-1:0]         poll_q, poll_d;
  logic [8*NUM_CTRL-1:0] shift_q, shift_d;
  logic [8*NUM_CTRL-1:0] buttons_q, buttons_d;
  logic [8*NUM_CTRL-1:0] pressed_q, pressed_d;
  logic                  valid_q, valid_d;
  logic                  latch_q, latch_d;
  logic                  pulse_q, pulse_d;
  logic [NUM_CTRL-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_CTRL-1:0]   data_s;
  logic                  tick;
  logic                  timer_done;
  logic                  sample;
  logic                  publish;

  assign data_s     = sync_q[SYNC_STAGES-1];
  assign tick       = poll_en && (poll_q == POLL_LAST);
  assign timer_done = (timer_q == '0);

  // Synchronisers idle at 1 so a reset never looks like a pressed button.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= nes_data;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    poll_d = poll_q;
    if (!poll_en || poll_q == POLL_LAST) poll_d = '0;
    else                                 poll_d = poll_q + PW'(1);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    valid_d   = 1'b0;
    sample    = 1'b0;
    publish   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_LATCH;
          timer_d = LATCH_LAST;
          bit_d   = 3'd0;
        end
      end
      S_LATCH: begin
        if (timer_done) begin
          sample  = 1'b1;
          state_d = S_P_HIGH;
          timer_d = HALF_LAST;
          bit_d   = 3'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_P_HIGH: begin
        if (timer_done) begin
          state_d = S_P_LOW;
          timer_d = HALF_LAST;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_P_LOW: begin
        if (timer_done) begin
          sample = 1'b1;
          if (bit_q == 3'd7) begin
            publish = 1'b1;
            state_d = S_DONE;
            bit_d   = 3'd0;
          end else begin
            state_d = S_P_HIGH;
            timer_d = HALF_LAST;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        bit_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase

    if (sample) begin
      for (int c = 0; c < NUM_CTRL; c++)
        for (int b = 0; b < 8; b++)
          if (bit_q == 3'(b)) shift_d[8*c+b] = data_s[c];
    end

    // The last bit lands in shift_d this cycle, so publish from shift_d
    // to have results registered in the DONE cycle itself.
    if (publish) begin
      buttons_d = ~shift_d;
      pressed_d = ~shift_d & ~buttons_q;
      valid_d   = 1'b1;
    end

    latch_d = (state_d == S_LATCH);
    pulse_d = (state_d == S_P_HIGH);
  end

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      poll_q    <= '0;
      shift_q   <= '1;
      buttons_q <= '0;
      pressed_q <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      poll_q    <= poll_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
    end
  end

  assign nes_latch = latch_q;
  assign nes_pulse = pulse_q;
  assign buttons   = buttons_q;
  assign pressed   = pressed_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_nes_multi_reader.sv
// Bench for nes_multi_reader: two modelled NES pads (parallel load while
// latch is high, shift on pulse rising edge) and a frame-level reference
// that predicts buttons/pressed from what each pad held at its latch.
module tb_nes_multi_reader;
  localparam int NC = 2;
  localparam int HP = 4;
  localparam int PC = 100;
  localparam int SS = 2;
  localparam int W  = 8 * NC;

  logic          clk = 1'b0;
  logic          hard_reset = 1'b1;
  logic          poll_en = 1'b0;
  logic [NC-1:0] nes_data;
  logic          nes_latch, nes_pulse, valid;
  logic [W-1:0]  buttons, pressed;

  logic [7:0]    pad_btn [NC];
  logic [NC-1:0] pad_conn;
  logic [7:0]    ctrl_sr [NC];
  logic [W-1:0]  exp_frame;
  logic [W-1:0]  exp_prev;

  int errors = 0;
  int checks = 0;

  nes_multi_reader #(
    .NUM_CTRL(NC), .HALF_PERIOD(HP), .POLL_CYCLES(PC), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .hard_reset(hard_reset), .poll_en(poll_en),
    .nes_data(nes_data), .nes_latch(nes_latch), .nes_pulse(nes_pulse),
    .buttons(buttons), .pressed(pressed), .valid(valid)
  );

  always #5 clk = ~clk;

  // Pad model plus snapshot of what each pad reports this frame.
  always @(posedge nes_latch or posedge nes_pulse) begin
    for (int c = 0; c < NC; c++) begin
      if (nes_latch) begin
        ctrl_sr[c] <= ~pad_btn[c];
        exp_frame[8*c +: 8] <= pad_conn[c] ? pad_btn[c] : 8'h00;
      end else begin
        ctrl_sr[c] <= {1'b1, ctrl_sr[c][7:1]};
      end
    end
  end

  always_comb begin
    nes_data = '1;
    for (int c = 0; c < NC; c++)
      if (pad_conn[c]) nes_data[c] = ctrl_sr[c][0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    hard_reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit found, output int steps);
    found = 1'b0;
    steps = 0;
    while (!found && steps < limit) begin
      step();
      steps++;
      if (valid) found = 1'b1;
    end
  endtask

  function automatic void model_publish(output logic [W-1:0] eb, output logic [W-1:0] ep);
    eb = exp_frame;
    ep = exp_frame & ~exp_prev;
    exp_prev = exp_frame;
  endfunction

  task automatic test_reset();
    hard_reset = 1'b1;
    poll_en = 1'b1;
    pad_conn = '1;
    for (int c = 0; c < NC; c++) pad_btn[c] = 8'h00;
    #1;
    checks++;
    if (nes_latch !== 1'b0 || nes_pulse !== 1'b0)
      $display("FAIL reset_pads: latch=%b pulse=%b want 0 0", nes_latch, nes_pulse);
    else checks += 0;
    if (nes_latch !== 1'b0 || nes_pulse !== 1'b0) errors++;
    checks++;
    if (buttons !== '0 || pressed !== '0 || valid !== 1'b0) begin
      $display("FAIL reset_outputs: buttons=%h pressed=%h valid=%b want 0", buttons, pressed, valid);
      errors++;
    end
    repeat (3) step();
    checks++;
    if (nes_latch !== 1'b0 || valid !== 1'b0 || buttons !== '0) begin
      $display("FAIL reset_held: latch=%b valid=%b buttons=%h want 0", nes_latch, valid, buttons);
      errors++;
    end
  endtask

  task automatic test_frame_timing();
    int lrise[$];
    int prise[$];
    int vcyc[$];
    int latch_hi = 0;
    int pulse_hi = 0;
    int pbad = 0;
    logic pl = 1'b0;
    logic pp = 1'b0;
    logic [W-1:0] vb = '0, vp = '0, eb, ep;
    release_rst();
    exp_prev = '0;
    for (int n = 1; n <= 2 * PC; n++) begin
      step();
      if (nes_latch && !pl) lrise.push_back(n);
      if (nes_pulse && !pp) prise.push_back(n);
      if (nes_latch && n < 2 * PC) latch_hi++;
      if (nes_pulse) pulse_hi++;
      if (valid) begin
        vcyc.push_back(n);
        vb = buttons;
        vp = pressed;
      end
      pl = nes_latch;
      pp = nes_pulse;
    end
    checks++;
    if (lrise.size() != 2 || lrise[0] != PC || lrise[1] != 2 * PC) begin
      $display("FAIL latch_rise: count=%0d first=%0d want 2 rises at %0d,%0d",
               lrise.size(), (lrise.size() > 0) ? lrise[0] : -1, PC, 2 * PC);
      errors++;
    end
    checks++;
    if (latch_hi != 2 * HP) begin
      $display("FAIL latch_width: got=%0d want=%0d", latch_hi, 2 * HP);
      errors++;
    end
    if (prise.size() != 7) pbad++;
    foreach (prise[j]) if (prise[j] != PC + 2 * HP + 2 * HP * j) pbad++;
    checks++;
    if (pbad != 0) begin
      $display("FAIL pulse_rises: count=%0d first=%0d want 7 starting %0d every %0d",
               prise.size(), (prise.size() > 0) ? prise[0] : -1, PC + 2 * HP, 2 * HP);
      errors++;
    end
    checks++;
    if (pulse_hi != 7 * HP) begin
      $display("FAIL pulse_width: high cycles=%0d want=%0d", pulse_hi, 7 * HP);
      errors++;
    end
    checks++;
    if (vcyc.size() != 1 || vcyc[0] != PC + 16 * HP) begin
      $display("FAIL valid_time: count=%0d at=%0d want 1 at %0d",
               vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, PC + 16 * HP);
      errors++;
    end
    model_publish(eb, ep);
    checks++;
    if (vb !== eb || vp !== ep) begin
      $display("FAIL first_frame: buttons=%h pressed=%h want %h %h", vb, vp, eb, ep);
      errors++;
    end
  endtask

  task automatic test_directed_buttons();
    logic [7:0]   s0 [3] = '{8'h09, 8'h09, 8'h08};
    logic [7:0]   s1 [3] = '{8'h00, 8'h00, 8'h40};
    logic [W-1:0] xb [3] = '{16'h0009, 16'h0009, 16'h4008};
    logic [W-1:0] xp [3] = '{16'h0009, 16'h0000, 16'h4000};
    logic [W-1:0] eb, ep;
    bit f;
    int st;
    wait_valid(3 * PC, f, st);
    model_publish(eb, ep);
    checks++;
    if (!f || buttons !== eb) begin
      $display("FAIL inflight_frame: found=%b buttons=%h want %h", f, buttons, eb);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      pad_btn[0] = s0[i];
      pad_btn[1] = s1[i];
      wait_valid(3 * PC, f, st);
      model_publish(eb, ep);
      checks++;
      if (!f || buttons !== xb[i] || pressed !== xp[i]) begin
        $display("FAIL directed_%0d: found=%b buttons=%h pressed=%h want %h %h",
                 i, f, buttons, pressed, xb[i], xp[i]);
        errors++;
      end
      step();
      checks++;
      if (valid !== 1'b0 || pressed !== '0 || buttons !== xb[i]) begin
        $display("FAIL directed_pulse_%0d: valid=%b pressed=%h buttons=%h want 0 0 %h",
                 i, valid, pressed, buttons, xb[i]);
        errors++;
      end
    end
  endtask

  task automatic test_unconnected();
    logic [W-1:0] eb, ep;
    bit f;
    int st;
    pad_conn = '0;
    for (int c = 0; c < NC; c++) pad_btn[c] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      wait_valid(3 * PC, f, st);
      model_publish(eb, ep);
      checks++;
      if (!f || buttons !== '0 || pressed !== '0) begin
        $display("FAIL unconnected_%0d: found=%b buttons=%h pressed=%h want 0 0",
                 i, f, buttons, pressed);
        errors++;
      end
      if (i == 1) begin
        checks++;
        if (st != PC) begin
          $display("FAIL valid_period: got=%0d want=%0d", st, PC);
          errors++;
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] eb, ep;
    bit f;
    int st;
    for (int i = 0; i < 8; i++) begin
      pad_conn = NC'($urandom_range(0, 3));
      for (int c = 0; c < NC; c++) pad_btn[c] = 8'($urandom);
      wait_valid(3 * PC, f, st);
      model_publish(eb, ep);
      checks++;
      if (!f || buttons !== eb || pressed !== ep) begin
        $display("FAIL random_%0d: found=%b buttons=%h pressed=%h want %h %h",
                 i, f, buttons, pressed, eb, ep);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] eb, ep;
    bit f;
    int st;
    int rises = 0;
    int vcount = 0;
    int lfirst = -1;
    logic pp = 1'b0;
    logic pl = 1'b0;
    pad_conn = '1;
    pad_btn[0] = 8'hA5;
    pad_btn[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      wait_valid(3 * PC, f, st);
      model_publish(eb, ep);
    end
    checks++;
    if (!f || buttons !== 16'h3CA5) begin
      $display("FAIL pre_reset_buttons: buttons=%h want 3ca5", buttons);
      errors++;
    end
    for (int n = 0; n < 3 * PC && rises < 3; n++) begin
      step();
      if (nes_pulse && !pp) rises++;
      pp = nes_pulse;
    end
    #2;
    hard_reset = 1'b1;
    #1;
    checks++;
    if (rises != 3 || nes_pulse !== 1'b0 || buttons !== '0 || pressed !== '0) begin
      $display("FAIL async_reset: rises=%0d pulse=%b buttons=%h pressed=%h want 3 0 0 0",
               rises, nes_pulse, buttons, pressed);
      errors++;
    end
    exp_prev = '0;
    release_rst();
    for (int n = 1; n <= PC + 10; n++) begin
      step();
      if (valid) vcount++;
      if (nes_latch && !pl && lfirst < 0) lfirst = n;
      pl = nes_latch;
    end
    checks++;
    if (vcount != 0 || lfirst != PC) begin
      $display("FAIL post_reset: valids=%0d latch_at=%0d want 0 %0d", vcount, lfirst, PC);
      errors++;
    end
  endtask

  task automatic test_poll_disable();
    logic [W-1:0] eb, ep;
    bit f;
    int st;
    int vcount = 0;
    int lrises = 0;
    int lfirst = -1;
    int waited = 0;
    logic [W-1:0] vb = '0;
    logic pl;
    wait_valid(3 * PC, f, st);
    model_publish(eb, ep);
    checks++;
    if (!f || buttons !== eb || pressed !== ep) begin
      $display("FAIL after_reset_frame: buttons=%h pressed=%h want %h %h", buttons, pressed, eb, ep);
      errors++;
    end
    while (!nes_latch && waited < 2 * PC) begin
      step();
      waited++;
    end
    step();
    step();
    poll_en = 1'b0;
    pl = nes_latch;
    for (int n = 0; n < 4 * PC; n++) begin
      step();
      if (valid) begin
        vcount++;
        vb = buttons;
      end
      if (nes_latch && !pl) lrises++;
      pl = nes_latch;
    end
    model_publish(eb, ep);
    checks++;
    if (vcount != 1 || lrises != 0 || vb !== eb) begin
      $display("FAIL poll_disable: valids=%0d latches=%0d buttons=%h want 1 0 %h",
               vcount, lrises, vb, eb);
      errors++;
    end
    poll_en = 1'b1;
    pl = nes_latch;
    for (int n = 1; n <= PC + 5; n++) begin
      step();
      if (nes_latch && !pl && lfirst < 0) lfirst = n;
      pl = nes_latch;
    end
    checks++;
    if (lfirst != PC) begin
      $display("FAIL reenable_latch: at=%0d want=%0d", lfirst, PC);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_directed_buttons();
    test_unconnected();
    test_random();
    test_reset_mid_frame();
    test_poll_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nes_multi_reader.md
Name: nes_multi_reader

Overview:
Pad-side controller front end for the Tetris ASIC. It drives the NES latch and pulse pads and samples 1..4 serial controller data pads through synchronisers. It publishes debounced-by-frame button vectors plus rising-edge "pressed" pulses to the game core. It replaces the single raw nes_in path with a parametrised, self-timed poller.

Parameters:
NUM_CTRL, 1, number of controller data pads (legal 1..4).
HALF_PERIOD, 300, clk cycles per half NES bit period (6 us at 50 MHz); must be > SYNC_STAGES+1.
POLL_CYCLES, 833333, clk cycles between frame starts (60 Hz at 50 MHz); must be > 16*HALF_PERIOD+2.
SYNC_STAGES, 2, flops per data-pad synchroniser (legal >= 2).

Ports:
clk  input  1  system clock
hard_reset  input  1  asynchronous, active-high reset
poll_en  input  1  1 = free-running polling enabled
nes_data  input  NUM_CTRL  raw serial data from pads, active-low (0 = button pressed)
nes_latch  output  1  controller latch strobe, active-high
nes_pulse  output  1  controller shift clock, active-high
buttons  output  8*NUM_CTRL  held state, active-high; per controller c, bits [8c+7:8c] = Right,Left,Down,Up,Start,Select,B,A (bit 0 = A)
pressed  output  8*NUM_CTRL  one-cycle pulse, buttons bits that went 0->1 this frame
valid  output  1  one-cycle pulse when buttons/pressed are updated

Behaviour:
- Reset (async, immediate): nes_latch=0, nes_pulse=0, buttons=0, pressed=0, valid=0, FSM=IDLE, poll counter=0, bit counter=0, synchroniser flops=1 (idle level), shift registers=all 1.
- Reset mid-frame aborts the frame with no publish. The first latch follows POLL_CYCLES cycles after deassertion.
- Poll counter: counts 0..POLL_CYCLES-1 and wraps while poll_en=1. It is held at 0 while poll_en=0. The tick is the cycle the count equals POLL_CYCLES-1.
- poll_en=0 does not abort an in-progress frame; it completes and publishes.
- FSM states:
  - IDLE: outputs low. Go to LATCH on the cycle after a tick.
  - LATCH: nes_latch=1 for 2*HALF_PERIOD cycles. On its last cycle, sample bit 0 of every channel from the synchroniser output. Go to P_HIGH.
  - P_HIGH: nes_pulse=1 for HALF_PERIOD cycles. Go to P_LOW.
  - P_LOW: nes_pulse=0 for HALF_PERIOD cycles. On its last cycle, sample bit k (k=1..7, bit counter). If k=7, go to DONE; else increment k and go to P_HIGH.
  - DONE: one cycle. buttons <= ~shift; pressed <= ~shift & ~buttons_old; valid=1. Go to IDLE.
- Frame timing: latch rises 1 cycle after the tick. valid is asserted 16*HALF_PERIOD cycles after the latch rise cycle.
- pressed and valid are high for exactly one cycle, registered in DONE. Both are 0 in all other cycles.
- A tick while the FSM is not IDLE is ignored (unreachable under the parameter constraints).
- An unconnected pad (pulled high) reads all 1s, giving buttons=0 for that channel.
- All channels share latch/pulse timing and are sampled on the same cycle.
- nes_latch and nes_pulse are registered outputs (glitch-free to pads).

Test Plan:
(Bench parameters: NUM_CTRL=2, HALF_PERIOD=4, POLL_CYCLES=100, SYNC_STAGES=2. Controller model shifts on pulse rising edge.)
- Release reset at cycle 0, poll_en=1 -> nes_latch rises at cycle 100, high 8 cycles; then 7 pulses of 4 high/4 low; valid single-cycle at cycle 164; next latch at cycle 200.
- Ctrl0 pressing A+Start (bits 0,3 low), ctrl1 idle -> at valid: buttons=16'h0009, pressed=16'h0009.
- Same input on next frame -> buttons=16'h0009, pressed=16'h0000. Then release A and press Left on ctrl1 -> buttons=16'h4008, pressed=16'h4000.
- Both pads tied high -> buttons=16'h0000, pressed=16'h0000, valid still pulses every 100 cycles.
- Assert hard_reset during the 3rd pulse-high -> nes_pulse, buttons and pressed go 0 without waiting for a clk edge; no valid that frame; after release, latch rises 100 cycles later.
- Drop poll_en during LATCH -> frame completes and valid pulses once; no further latch until poll_en=1, then latch rises 100 cycles after re-enable.
